// File: rtl/fp_to_uint_seq.sv
// Iterative IEEE754 to unsigned integer converter, truncating toward zero.
// One alignment shift per clock; valid/ready handshakes on input and output.
module fp_to_uint_seq #(
    parameter int NX   = 8,
    parameter int NM   = 23,
    parameter int NOUT = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [NX+NM:0]     IN_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [NOUT-1:0]    OUT_DATA,
    output logic [2:0]         OUT_FLAGS
);

    localparam int W    = (NM + 1 > NOUT) ? NM + 1 : NOUT;
    localparam int CW   = $clog2(W + 1);
    localparam int BIAS = (1 << (NX - 1)) - 1;
    localparam logic [NX:0] BIAS_V = BIAS[NX:0];

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            sticky_q, sticky_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [NOUT-1:0] out_data_q, out_data_d;
    logic [2:0]      out_flags_q, out_flags_d;

    logic            in_sign;
    logic [NX-1:0]   in_exp;
    logic [NM-1:0]   in_mant;
    logic [NX:0]     e_val;
    int              e_int;
    int              cnt_full;
    logic [W-1:0]    sig_ext;
    logic [W-1:0]    shifted;
    logic            sticky_next;

    assign in_sign = IN_DATA[NX+NM];
    assign in_exp  = IN_DATA[NX+NM-1:NM];
    assign in_mant = IN_DATA[NM-1:0];

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        sticky_d    = sticky_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;

        e_val    = {1'b0, in_exp} - BIAS_V;
        e_int    = int'($signed(e_val));
        cnt_full = (e_int <= NM) ? (NM - e_int) : (e_int - NM);
        sig_ext  = '0;
        sig_ext[NM:0] = {1'b1, in_mant};

        shifted     = left_q ? {work_q[W-2:0], 1'b0} : {1'b0, work_q[W-1:1]};
        sticky_next = sticky_q | (~left_q & work_q[0]);

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    in_ready_d = 1'b0;
                    state_d    = DONE;
                    out_data_d = '0;
                    // Classification order matters: zero/denormal before Inf/NaN before sign
                    if (in_exp == '0) begin
                        out_flags_d = {1'b0, in_sign & (in_mant != '0), in_mant != '0};
                    end else if (in_exp == '1) begin
                        out_data_d  = '1;
                        out_flags_d = 3'b100;
                    end else if (in_sign) begin
                        out_flags_d = 3'b010;
                    end else if (e_int < 0) begin
                        out_flags_d = 3'b001;
                    end else if (e_int >= NOUT) begin
                        out_data_d  = '1;
                        out_flags_d = 3'b100;
                    end else begin
                        work_d   = sig_ext;
                        cnt_d    = cnt_full[CW-1:0];
                        left_d   = (e_int > NM);
                        sticky_d = 1'b0;
                        if (cnt_full == 0) begin
                            out_data_d  = sig_ext[NOUT-1:0];
                            out_flags_d = 3'b000;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                    out_valid_d = (state_d == DONE);
                end
            end
            SHIFT: begin
                work_d   = shifted;
                sticky_d = sticky_next;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = shifted[NOUT-1:0];
                    out_flags_d = {2'b00, sticky_next};
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_FLAGS = out_flags_q;

endmodule

// File: tb/tb_fp_to_uint_seq.sv
// Directed bench for fp_to_uint_seq: conversions, latency, specials,
// backpressure, mid-operation reset and a back-to-back stream.
module tb_fp_to_uint_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] IN_DATA = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] OUT_DATA;
    logic [2:0]  OUT_FLAGS;

    int checks = 0;
    int failures = 0;

    fp_to_uint_seq #(.NX(8), .NM(23), .NOUT(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_FLAGS (OUT_FLAGS)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a word and holds it until the edge where IN_READY was high
    task automatic applyStimulus(input logic [31:0] word, output bit accepted);
        bit rdy;
        IN_DATA  = word;
        IN_VALID = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            rdy = IN_READY;
            @(posedge CLK); #1;
            if (rdy) accepted = 1'b1;
        end
        IN_VALID = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] word, input logic [15:0] exp_data,
                            input logic [2:0] exp_flags, input int exp_lat, input int hold);
        bit acc;
        bit saw_ready;
        int lat;
        logic [15:0] held_data;
        logic [2:0]  held_flags;
        applyStimulus(word, acc);
        checkOutput({tag, "/accept"}, 32'(acc), 32'd1);
        lat = 1;
        saw_ready = 1'b0;
        while (!OUT_VALID && lat < 100) begin
            if (IN_READY) saw_ready = 1'b1;
            @(posedge CLK); #1;
            lat++;
        end
        if (IN_READY) saw_ready = 1'b1;
        checkOutput({tag, "/valid"}, 32'(OUT_VALID), 32'd1);
        checkOutput({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "/data"}, 32'(OUT_DATA), 32'(exp_data));
        checkOutput({tag, "/flags"}, 32'(OUT_FLAGS), 32'(exp_flags));
        checkOutput({tag, "/busy_ready"}, 32'(saw_ready), 32'd0);
        held_data  = OUT_DATA;
        held_flags = OUT_FLAGS;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            checkOutput({tag, "/hold_valid"}, 32'(OUT_VALID), 32'd1);
            checkOutput({tag, "/hold_data"}, 32'(OUT_DATA), 32'(held_data));
            checkOutput({tag, "/hold_flags"}, 32'(OUT_FLAGS), 32'(held_flags));
            checkOutput({tag, "/hold_in_ready"}, 32'(IN_READY), 32'd0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        checkOutput({tag, "/drained"}, 32'(OUT_VALID), 32'd0);
        checkOutput({tag, "/in_ready_back"}, 32'(IN_READY), 32'd1);
    endtask

    logic [31:0] stream_in   [8] = '{32'h40490FDB, 32'h42C80000, 32'h3FC00000, 32'h461C4000,
                                     32'h4479FFFF, 32'h477FFF80, 32'h41200000, 32'h45800800};
    logic [15:0] stream_data [8] = '{16'd3, 16'd100, 16'd1, 16'd10000,
                                     16'd999, 16'hFFFF, 16'd10, 16'd4097};
    logic [2:0]  stream_flag [8] = '{3'b001, 3'b000, 3'b001, 3'b000,
                                     3'b001, 3'b001, 3'b000, 3'b000};

    initial begin
        bit acc;
        bit saw_valid;
        bit in_fire;
        bit out_fire;
        int idx_in;
        int idx_out;
        logic [15:0] cap_data;
        logic [2:0]  cap_flags;

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("reset/in_ready", 32'(IN_READY), 32'd1);
        checkOutput("reset/out_valid", 32'(OUT_VALID), 32'd0);
        checkOutput("reset/out_data", 32'(OUT_DATA), 32'd0);
        checkOutput("reset/out_flags", 32'(OUT_FLAGS), 32'd0);

        run_case("one",      32'h3F800000, 16'd1,     3'b000, 24, 0);
        run_case("300p75",   32'h43966000, 16'h012C,  3'b001, 16, 5);
        run_case("65535",    32'h477FFF00, 16'hFFFF,  3'b000, 9,  0);
        run_case("65536",    32'h47800000, 16'hFFFF,  3'b100, 1,  0);
        run_case("nan",      32'h7FC00000, 16'hFFFF,  3'b100, 1,  0);
        run_case("neg2",     32'hC0000000, 16'd0,     3'b010, 1,  0);
        run_case("negzero",  32'h80000000, 16'd0,     3'b000, 1,  0);
        run_case("half",     32'h3F000000, 16'd0,     3'b001, 1,  2);
        run_case("negdenorm",32'h80000001, 16'd0,     3'b011, 1,  0);

        // Abort an in-flight 1.0 with a one-cycle reset in cycle T+10
        applyStimulus(32'h3F800000, acc);
        checkOutput("abort/accept", 32'(acc), 32'd1);
        saw_valid = 1'b0;
        repeat (9) begin
            if (OUT_VALID) saw_valid = 1'b1;
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checkOutput("abort/in_ready", 32'(IN_READY), 32'd1);
        checkOutput("abort/out_valid", 32'(OUT_VALID), 32'd0);
        repeat (30) begin
            if (OUT_VALID) saw_valid = 1'b1;
            @(posedge CLK); #1;
        end
        checkOutput("abort/no_output", 32'(saw_valid), 32'd0);
        run_case("three", 32'h40400000, 16'd3, 3'b000, 23, 0);

        // Producer always valid, consumer ready at random
        idx_in  = 0;
        idx_out = 0;
        IN_DATA  = stream_in[0];
        IN_VALID = 1'b1;
        for (int cyc = 0; cyc < 2000 && idx_out < 8; cyc++) begin
            OUT_READY = 1'($urandom_range(0, 1));
            in_fire   = IN_VALID && IN_READY;
            out_fire  = OUT_VALID && OUT_READY;
            cap_data  = OUT_DATA;
            cap_flags = OUT_FLAGS;
            @(posedge CLK); #1;
            if (in_fire) begin
                idx_in++;
                if (idx_in < 8) IN_DATA = stream_in[idx_in];
                else IN_VALID = 1'b0;
            end
            if (out_fire) begin
                checkOutput($sformatf("stream%0d/data", idx_out), 32'(cap_data), 32'(stream_data[idx_out]));
                checkOutput($sformatf("stream%0d/flags", idx_out), 32'(cap_flags), 32'(stream_flag[idx_out]));
                idx_out++;
            end
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        checkOutput("stream/accepted", 32'(idx_in), 32'd8);
        checkOutput("stream/delivered", 32'(idx_out), 32'd8);
        saw_valid = 1'b0;
        repeat (30) begin
            if (OUT_VALID) saw_valid = 1'b1;
            @(posedge CLK); #1;
        end
        checkOutput("stream/no_extra", 32'(saw_valid), 32'd0);
        OUT_READY = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
